ring_switch_n: RTL

//  N-port slotted-ring packet switch, parametrised in port count, data width and FIFO depth.

---
 rtl/ring_switch_n.sv | 134 +++++++++++++
 1 files changed

// File: rtl/ring_switch_n.sv
// N-port slotted-ring packet switch: per-port ingress FIFO, one ring slot and egress FIFO.
// Packets circulate toward lower slot indices until every destination bit in their mask is served.
module ring_switch_n #(
    parameter int NPORTS     = 4,
    parameter int DWIDTH     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NPORTS-1:0]        in_valid,
    input  logic [NPORTS*DWIDTH-1:0] in_data,
    output logic [NPORTS-1:0]        in_suspend,
    output logic [NPORTS-1:0]        out_valid,
    output logic [NPORTS*DWIDTH-1:0] out_data,
    input  logic [NPORTS-1:0]        out_suspend,
    output logic [CNT_W-1:0]         pkts_in,
    output logic [CNT_W-1:0]         pkts_out,
    output logic [CNT_W-1:0]         pkts_dropped
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [DWIDTH-1:0] ing_mem [NPORTS][FIFO_DEPTH];
    logic [PW-1:0]     ing_rd  [NPORTS];
    logic [PW-1:0]     ing_wr  [NPORTS];
    logic [CW-1:0]     ing_cnt [NPORTS];
    logic [DWIDTH-1:0] eg_mem  [NPORTS][FIFO_DEPTH];
    logic [PW-1:0]     eg_rd   [NPORTS];
    logic [PW-1:0]     eg_wr   [NPORTS];
    logic [CW-1:0]     eg_cnt  [NPORTS];

    // slot_mask holds the destinations still owed; a slot is occupied when it is non-zero
    logic [DWIDTH-1:0] slot_data [NPORTS];
    logic [NPORTS-1:0] slot_mask [NPORTS];

    logic [NPORTS-1:0] ing_push;
    logic [NPORTS-1:0] inject;
    logic [NPORTS-1:0] deliver;
    logic [NPORTS-1:0] eg_pop;
    logic [NPORTS-1:0] upd_mask [NPORTS];
    logic [NPORTS-1:0] nxt_mask [NPORTS];
    logic [DWIDTH-1:0] nxt_data [NPORTS];
    logic [CNT_W-1:0]  add_in;
    logic [CNT_W-1:0]  add_out;
    logic [CNT_W-1:0]  add_drop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        add_in   = '0;
        add_out  = '0;
        add_drop = '0;
        eg_pop   = '0;
        deliver  = '0;
        ing_push = '0;
        inject   = '0;
        for (int i = 0; i < NPORTS; i++) begin
            eg_pop[i]  = (eg_cnt[i] != '0) && !out_suspend[i];
            // a full egress FIFO still accepts when it pops in the same cycle
            deliver[i] = slot_mask[i][i] && ((eg_cnt[i] != CW'(FIFO_DEPTH)) || eg_pop[i]);
            upd_mask[i]    = slot_mask[i];
            upd_mask[i][i] = slot_mask[i][i] && !deliver[i];
            ing_push[i] = in_valid[i] && (in_data[i*DWIDTH +: NPORTS] != '0)
                          && (ing_cnt[i] != CW'(FIFO_DEPTH));
            if (in_valid[i] && !ing_push[i]) add_drop = add_drop + CNT_W'(1);
            if (ing_push[i]) add_in = add_in + CNT_W'(1);
            if (eg_pop[i]) add_out = add_out + CNT_W'(1);
        end
        for (int j = 0; j < NPORTS; j++) begin
            nxt_mask[j] = upd_mask[(j + 1) % NPORTS];
            nxt_data[j] = slot_data[(j + 1) % NPORTS];
            inject[j]   = (nxt_mask[j] == '0) && (ing_cnt[j] != '0);
            if (inject[j]) begin
                nxt_data[j] = ing_mem[j][ing_rd[j]];
                nxt_mask[j] = ing_mem[j][ing_rd[j]][NPORTS-1:0];
            end
        end
    end

    always_comb begin
        in_suspend = '0;
        for (int i = 0; i < NPORTS; i++)
            in_suspend[i] = (ing_cnt[i] >= CW'(FIFO_DEPTH - 1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NPORTS; i++) begin
                ing_rd[i]    <= '0;
                ing_wr[i]    <= '0;
                ing_cnt[i]   <= '0;
                eg_rd[i]     <= '0;
                eg_wr[i]     <= '0;
                eg_cnt[i]    <= '0;
                slot_mask[i] <= '0;
                slot_data[i] <= '0;
            end
            out_valid    <= '0;
            out_data     <= '0;
            pkts_in      <= '0;
            pkts_out     <= '0;
            pkts_dropped <= '0;
        end else begin
            for (int i = 0; i < NPORTS; i++) begin
                if (ing_push[i]) ing_wr[i] <= ptr_inc(ing_wr[i]);
                if (inject[i]) ing_rd[i] <= ptr_inc(ing_rd[i]);
                ing_cnt[i] <= ing_cnt[i] + CW'(ing_push[i]) - CW'(inject[i]);
                if (deliver[i]) eg_wr[i] <= ptr_inc(eg_wr[i]);
                if (eg_pop[i]) begin
                    eg_rd[i] <= ptr_inc(eg_rd[i]);
                    out_data[i*DWIDTH +: DWIDTH] <= eg_mem[i][eg_rd[i]];
                end
                eg_cnt[i]    <= eg_cnt[i] + CW'(deliver[i]) - CW'(eg_pop[i]);
                slot_mask[i] <= nxt_mask[i];
                slot_data[i] <= nxt_data[i];
            end
            out_valid    <= eg_pop;
            pkts_in      <= pkts_in + add_in;
            pkts_out     <= pkts_out + add_out;
            pkts_dropped <= pkts_dropped + add_drop;
        end
    end

    // FIFO storage needs no reset; emptiness lives in the pointers and counts
    always_ff @(posedge clk) begin
        for (int i = 0; i < NPORTS; i++) begin
            if (ing_push[i]) ing_mem[i][ing_wr[i]] <= in_data[i*DWIDTH +: DWIDTH];
            if (deliver[i]) eg_mem[i][eg_wr[i]] <= slot_data[i];
        end
    end
endmodule
